// File: rtl/pipe_block_throttle_if.sv
// Pipe-endpoint/FIFO bundle for pipe_block_throttle: fill counts, strobes, ready and sticky error flags.
// master drives counts/strobes/err_clr; slave (the throttle) drives ready and err.
interface pipe_block_throttle_if #(
  parameter int unsigned N_IN  = 1,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CNT_W = 10
);
  logic [N_IN*CNT_W-1:0]  in_wr_count;
  logic [N_IN-1:0]        in_ep_write;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN-1:0]        in_err;
  logic [N_OUT*CNT_W-1:0] out_rd_count;
  logic [N_OUT-1:0]       out_ep_read;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT-1:0]       out_err;
  logic                   err_clr;

  modport master (
    output in_wr_count, in_ep_write, out_rd_count, out_ep_read, err_clr,
    input  in_ready, in_err, out_ready, out_err
  );

  modport slave (
    input  in_wr_count, in_ep_write, out_rd_count, out_ep_read, err_clr,
    output in_ready, in_err, out_ready, out_err
  );
endinterface

// File: rtl/pipe_block_throttle.sv
// Multi-channel block throttle: per-channel ready from registered FIFO counts, block tracking and settle window.
// Define PIPE_THROTTLE_STATS_EN to add per-channel completed-block counters (blk_done_in / blk_done_out).
module pipe_block_throttle #(
  parameter int unsigned N_IN   = 1,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned BLOCK  = 128,
  parameter int unsigned SETTLE = 4
) (
  input  logic                      okClk,
  input  logic                      rst_n,
  pipe_block_throttle_if.slave      bus
`ifdef PIPE_THROTTLE_STATS_EN
  ,
  output logic [N_IN*16-1:0]        blk_done_in,
  output logic [N_OUT*16-1:0]       blk_done_out
`endif
);

  localparam int unsigned NCH  = N_IN + N_OUT;
  localparam int unsigned WC_W = $clog2(BLOCK + 1);
  localparam int unsigned SC_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W:0] SPACE_IN  = (CNT_W+1)'(DEPTH - BLOCK);
  localparam logic [CNT_W:0] SPACE_OUT = (CNT_W+1)'(BLOCK);

  typedef enum logic [1:0] {IDLE, ARMED, XFER, SETTLE_ST} state_t;

  // Input channels occupy indices [0, N_IN), output channels follow.
  logic [NCH*CNT_W-1:0] cnt_flat;
  logic [NCH-1:0]       strobe;
  logic [NCH-1:0]       ready;
  logic [NCH-1:0]       err;
  logic [NCH*16-1:0]    blk_done;

  assign cnt_flat      = {bus.out_rd_count, bus.in_wr_count};
  assign strobe        = {bus.out_ep_read, bus.in_ep_write};
  assign bus.in_ready  = ready[N_IN-1:0];
  assign bus.out_ready = ready[NCH-1:N_IN];
  assign bus.in_err    = err[N_IN-1:0];
  assign bus.out_err   = err[NCH-1:N_IN];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic             space;
    logic [WC_W-1:0]  words;
    logic [SC_W-1:0]  settle_cnt;
    logic             rdy_q;
    logic             err_q;
    logic [15:0]      done_q;

    if (c < N_IN) begin : g_in
      assign space = ({1'b0, cnt_q} <= SPACE_IN);
    end else begin : g_out
      assign space = ({1'b0, cnt_q} >= SPACE_OUT);
    end

    assign ready[c]                = rdy_q;
    assign err[c]                  = err_q;
    assign blk_done[c*16 +: 16]    = done_q;

    // rdy_q is loaded with (next state == ARMED) so it always matches the state register.
    always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
        state      <= IDLE;
        cnt_q      <= '0;
        words      <= '0;
        settle_cnt <= '0;
        rdy_q      <= 1'b0;
        err_q      <= 1'b0;
        done_q     <= '0;
      end else begin
        cnt_q <= cnt_flat[c*CNT_W +: CNT_W];
        err_q <= err_q & ~bus.err_clr;
        case (state)
          IDLE: begin
            if (strobe[c]) begin
              err_q <= 1'b1;
              rdy_q <= 1'b0;
            end else if (space) begin
              state <= ARMED;
              rdy_q <= 1'b1;
            end else begin
              rdy_q <= 1'b0;
            end
          end
          ARMED: begin
            if (strobe[c]) begin
              rdy_q <= 1'b0;
              if (BLOCK == 1) begin
                state      <= SETTLE_ST;
                settle_cnt <= SC_W'(SETTLE);
                words      <= '0;
`ifdef PIPE_THROTTLE_STATS_EN
                done_q     <= done_q + 16'd1;
`endif
              end else begin
                state <= XFER;
                words <= WC_W'(1);
              end
            end else if (!space) begin
              state <= IDLE;
              rdy_q <= 1'b0;
            end else begin
              rdy_q <= 1'b1;
            end
          end
          XFER: begin
            rdy_q <= 1'b0;
            if (strobe[c]) begin
              if (words == WC_W'(BLOCK - 1)) begin
                state      <= SETTLE_ST;
                settle_cnt <= SC_W'(SETTLE);
                words      <= '0;
`ifdef PIPE_THROTTLE_STATS_EN
                done_q     <= done_q + 16'd1;
`endif
              end else begin
                words <= words + WC_W'(1);
              end
            end
          end
          SETTLE_ST: begin
            rdy_q <= 1'b0;
            if (strobe[c]) err_q <= 1'b1;
            if (settle_cnt == '0) state <= IDLE;
            else                  settle_cnt <= settle_cnt - SC_W'(1);
          end
          default: begin
            state <= IDLE;
            rdy_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PIPE_THROTTLE_STATS_EN
  assign blk_done_in  = blk_done[N_IN*16-1:0];
  assign blk_done_out = blk_done[NCH*16-1:N_IN*16];
`else
  logic unused_blk_done;
  assign unused_blk_done = ^blk_done;
`endif

endmodule

// File: tb/tb_pipe_block_throttle.sv
// Randomized self-checking bench for pipe_block_throttle (2 in / 2 out channels) against a block-level model.
// Honours PIPE_THROTTLE_STATS_EN by also checking the completed-block counters.
module tb_pipe_block_throttle;
  localparam int N_IN = 2, N_OUT = 2, CNT_W = 10;
  localparam int DEPTH = 1024, BLOCK = 128, SETTLE = 4;
  localparam int NCH = N_IN + N_OUT;

  logic okClk = 1'b0;
  logic rst_n = 1'b0;
  always #5 okClk = ~okClk;

  pipe_block_throttle_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();
`ifdef PIPE_THROTTLE_STATS_EN
  logic [N_IN*16-1:0]  blk_done_in;
  logic [N_OUT*16-1:0] blk_done_out;
`endif

  pipe_block_throttle #(
    .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W),
    .DEPTH(DEPTH), .BLOCK(BLOCK), .SETTLE(SETTLE)
  ) dut (
    .okClk(okClk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef PIPE_THROTTLE_STATS_EN
    ,
    .blk_done_in(blk_done_in),
    .blk_done_out(blk_done_out)
`endif
  );

  // Stimulus: channel c < N_IN is an input channel, otherwise output channel c-N_IN.
  logic [CNT_W-1:0] cnt_v [NCH];
  logic             stb   [NCH];
  logic             clr;

  always_comb begin
    bus.in_wr_count  = '0;
    bus.out_rd_count = '0;
    bus.in_ep_write  = '0;
    bus.out_ep_read  = '0;
    for (int i = 0; i < N_IN; i++) begin
      bus.in_wr_count[i*CNT_W +: CNT_W] = cnt_v[i];
      bus.in_ep_write[i]                = stb[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      bus.out_rd_count[j*CNT_W +: CNT_W] = cnt_v[N_IN+j];
      bus.out_ep_read[j]                 = stb[N_IN+j];
    end
    bus.err_clr = clr;
  end

  int vectors = 0;
  int miscompares = 0;

  // Block-level model: armed flag, words still owed in the current block, post-block hold countdown.
  bit m_arm  [NCH];
  int m_left [NCH];
  int m_hold [NCH];
  bit m_err  [NCH];
  int m_cq   [NCH];
  int m_done [NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_arm[c] = 0; m_left[c] = 0; m_hold[c] = -1;
      m_err[c] = 0; m_cq[c] = 0;   m_done[c] = 0;
    end
  endfunction

  function automatic void block_finished(int c);
    m_hold[c] = SETTLE;
    m_done[c] = (m_done[c] + 1) % 65536;
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NCH; c++) begin
      bit sp, ne;
      ne = 0;
      sp = (c < N_IN) ? (m_cq[c] <= DEPTH - BLOCK) : (m_cq[c] >= BLOCK);
      if (m_hold[c] >= 0) begin
        if (stb[c]) ne = 1;
        m_hold[c] = m_hold[c] - 1;
      end else if (m_left[c] > 0) begin
        if (stb[c]) begin
          m_left[c]--;
          if (m_left[c] == 0) block_finished(c);
        end
      end else if (m_arm[c]) begin
        if (stb[c]) begin
          m_arm[c]  = 0;
          m_left[c] = BLOCK - 1;
          if (m_left[c] == 0) block_finished(c);
        end else if (!sp) begin
          m_arm[c] = 0;
        end
      end else begin
        if (stb[c]) ne = 1;
        else if (sp) m_arm[c] = 1;
      end
      m_err[c] = (m_err[c] && !clr) || ne;
      m_cq[c]  = int'(cnt_v[c]);
    end
  endfunction

  function automatic logic [2*NCH-1:0] model_vec();
    logic [2*NCH-1:0] v;
    for (int c = 0; c < NCH; c++) begin
      v[c]       = m_arm[c];
      v[NCH + c] = m_err[c];
    end
    return v;
  endfunction

  function automatic logic [2*NCH-1:0] dut_vec();
    return {bus.out_err, bus.in_err, bus.out_ready, bus.in_ready};
  endfunction

`ifdef PIPE_THROTTLE_STATS_EN
  function automatic logic [NCH*16-1:0] model_done();
    logic [NCH*16-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*16 +: 16] = 16'(m_done[c]);
    return v;
  endfunction
`endif

  // Advance one clock; model consumes the inputs present at the edge. Returns #1 after the edge.
  task automatic step();
    if (rst_n) model_step();
    else       model_reset();
    @(posedge okClk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < NCH; c++) stb[c] = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < NCH; c++) cnt_v[c] = '0;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", dut_vec(), '0);
    end
    vectors++;
    @(posedge okClk); #3;
    rst_n = 1'b1;
    @(negedge okClk);
    for (int k = 0; k < 2; k++) begin
      step();
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_release cyc%0d: got %b want %b", k, dut_vec(), model_vec());
      end
      vectors++;
    end
    if ({bus.out_ready, bus.in_ready} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reset_ready_after_2: got %b want 0011", {bus.out_ready, bus.in_ready});
    end
    vectors++;
  endtask

  task automatic test_threshold();
    cnt_v[0] = 10'd896; cnt_v[1] = 10'd897;
    cnt_v[2] = 10'd127; cnt_v[3] = 10'd128;
    for (int k = 0; k < 3; k++) begin
      step();
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL threshold cyc%0d: got %b want %b", k, dut_vec(), model_vec());
      end
      vectors++;
    end
    if ({bus.out_ready, bus.in_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL threshold_boundary: got %b want 1001", {bus.out_ready, bus.in_ready});
    end
    vectors++;
  endtask

  // Full 128-word block on input channel 0 with its count frozen at 0.
  task automatic test_block(input string tag);
    cnt_v[0] = '0;
    for (int k = 0; k < 3; k++) step();
    if (bus.in_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_armed: got %b want 1", tag, bus.in_ready[0]);
    end
    vectors++;
    for (int w = 1; w <= BLOCK; w++) begin
      stb[0] = 1'b1;
      step();
      if (dut_vec() !== model_vec() || bus.in_ready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_word%0d: got %b want %b", tag, w, dut_vec(), model_vec());
      end
      vectors++;
    end
    stb[0] = 1'b0;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      step();
      if (bus.in_ready[0] !== (k == SETTLE + 2) || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL %s_settle%0d: got rdy %b want %b", tag, k, bus.in_ready[0], k == SETTLE + 2);
      end
      vectors++;
    end
`ifdef PIPE_THROTTLE_STATS_EN
    if ({blk_done_out, blk_done_in} !== model_done() || blk_done_in[15:0] !== 16'd1) begin
      miscompares++;
      $display("FAIL %s_blk_done: got %h want %h", tag, {blk_done_out, blk_done_in}, model_done());
    end
    vectors++;
`endif
  endtask

  task automatic test_err();
    cnt_v[1] = 10'd1000;
    step(); step();
    stb[1] = 1'b1; step(); stb[1] = 1'b0;
    if (bus.in_err[1] !== 1'b1 || dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL err_set: got %b want %b", dut_vec(), model_vec());
    end
    vectors++;
    clr = 1'b1; step(); clr = 1'b0;
    if (bus.in_err !== 2'b00 || dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL err_clear: got %b want %b", dut_vec(), model_vec());
    end
    vectors++;
    clr = 1'b1; stb[1] = 1'b1; step(); clr = 1'b0; stb[1] = 1'b0;
    if (bus.in_err[1] !== 1'b1 || dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL err_clr_collision: got %b want %b", dut_vec(), model_vec());
    end
    vectors++;
  endtask

  task automatic test_async_reset();
    cnt_v[0] = '0;
    step(); step();
    for (int w = 0; w < 50; w++) begin
      stb[0] = 1'b1; step();
    end
    stb[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", dut_vec(), '0);
    end
    vectors++;
    step(); step();
    rst_n = 1'b1;
    test_block("post_reset_block");
  endtask

  task automatic test_independent();
    clr = 1'b1; step(); clr = 1'b0;
    cnt_v[0] = '0; cnt_v[1] = 10'd1000; cnt_v[2] = '0; cnt_v[3] = '0;
    step(); step(); step();
    for (int w = 0; w < 20; w++) begin
      stb[0] = 1'b1;
      stb[3] = (w == 5);
      step();
      if (dut_vec() !== model_vec() || bus.in_ready[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL independent cyc%0d: got %b want %b", w, dut_vec(), model_vec());
      end
      vectors++;
    end
    stb[0] = 1'b0; stb[3] = 1'b0;
    if (bus.out_err !== 2'b10 || bus.in_err !== 2'b00) begin
      miscompares++;
      $display("FAIL independent_err: got out %b in %b want out 10 in 00", bus.out_err, bus.in_err);
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(7) == 0) begin
          case ($urandom_range(3))
            0:       cnt_v[c] = CNT_W'($urandom_range(1023));
            1:       cnt_v[c] = CNT_W'($urandom_range(899, 893));
            2:       cnt_v[c] = CNT_W'($urandom_range(130, 125));
            default: cnt_v[c] = CNT_W'((c < N_IN) ? $urandom_range(100) : $urandom_range(1023, 900));
          endcase
        end
        if (m_arm[c] || m_left[c] > 0) stb[c] = ($urandom_range(3) != 0);
        else                             stb[c] = ($urandom_range(49) == 0);
      end
      clr = ($urandom_range(29) == 0);
      step();
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %b want %b", cyc, dut_vec(), model_vec());
      end
      vectors++;
`ifdef PIPE_THROTTLE_STATS_EN
      if ({blk_done_out, blk_done_in} !== model_done()) begin
        miscompares++;
        $display("FAIL random_blk_done cyc%0d: got %h want %h", cyc, {blk_done_out, blk_done_in}, model_done());
      end
      vectors++;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_block("block");
    test_err();
    test_async_reset();
    test_independent();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
